// File: rtl/pc_ras_if.sv
// pc_ras_if: control/redirect inputs and PC/RAS status outputs of the fetch PC unit.
interface pc_ras_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    logic                       stall;
    logic                       trap;
    logic [XLEN-1:0]            trap_vec;
    logic                       jmp;
    logic                       rel;
    logic [XLEN-1:0]            nxt;
    logic                       call;
    logic                       ret;
    logic [XLEN-1:0]            cur;
    logic [XLEN-1:0]            epc;
    logic [$clog2(RAS_DEPTH):0] ras_cnt;
    logic                       ras_ovf;
    logic                       ras_unf;

    modport master (
        output stall, trap, trap_vec, jmp, rel, nxt, call, ret,
        input  cur, epc, ras_cnt, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, trap, trap_vec, jmp, rel, nxt, call, ret,
        output cur, epc, ras_cnt, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: fetch program counter with circular return-address stack and trap redirect.
module pc_ras #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = '0,
    parameter int               STEP      = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    pc_ras_if.slave    bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] cur_q, cur_d, epc_q, epc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   top_q, top_d, wa;
    logic            ovf_q, ovf_d, unf_q, unf_d, we;
    logic [XLEN-1:0] stack_q [RAS_DEPTH];
    logic [XLEN-1:0] tgt, ra, top_e;
    logic            empty, full;

    // top_q is the next free slot; the top entry lives one below it
    assign ra    = cur_q + XLEN'(STEP);
    assign tgt   = bus.rel ? cur_q + bus.nxt : bus.nxt;
    assign top_e = stack_q[top_q - PW'(1)];
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(RAS_DEPTH);

    always_comb begin
        cur_d = ra;
        epc_d = epc_q;
        cnt_d = cnt_q;
        top_d = top_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        we    = 1'b0;
        wa    = top_q;
        if (bus.trap) begin
            cur_d = bus.trap_vec;
            epc_d = cur_q;
        end else if (bus.stall) begin
            cur_d = cur_q;
        end else if (bus.jmp) begin
            cur_d = (bus.ret && !empty) ? top_e : tgt;
            unf_d = bus.ret && empty;
            if (bus.call && bus.ret && !empty) begin
                we = 1'b1;
                wa = top_q - PW'(1);
            end else if (bus.call) begin
                // a full stack wraps and overwrites its oldest entry
                we    = 1'b1;
                top_d = top_q + PW'(1);
                cnt_d = full ? cnt_q : cnt_q + CW'(1);
                ovf_d = full;
            end else if (bus.ret && !empty) begin
                top_d = top_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= RESET_VEC;
            epc_q <= '0;
            cnt_q <= '0;
            top_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cur_q <= cur_d;
            epc_q <= epc_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && we) stack_q[wa] <= ra;
    end

    assign bus.cur     = cur_q;
    assign bus.epc     = epc_q;
    assign bus.ras_cnt = cnt_q;
    assign bus.ras_ovf = ovf_q;
    assign bus.ras_unf = unf_q;
endmodule
